uart_tx_arbiter: RTL and testbench

//   Shares one uart_transmit instance between NUM_REQUESTERS console sources (e.g. per-core debug output).

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: character handshake bundle between console
// requesters, the arbiter and one uart_transmit instance.
//   req_valid[N]  requester i presents req_char[i]
//   req_char[N]   per-requester character
//   req_ack[N]    one-cycle accept pulse back to requester i
//   tx_en         start pulse to uart_transmit
//   tx_char       character to uart_transmit
//   tx_ready      uart_transmit idle
// slave = arbiter view, master = requesters plus transmitter view.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]      req_valid;
    logic [N-1:0][7:0] req_char;
    logic [N-1:0]      req_ack;
    logic              tx_en;
    logic [7:0]        tx_char;
    logic              tx_ready;

    modport master (
        output req_valid, req_char, tx_ready,
        input  req_ack, tx_en, tx_char
    );

    modport slave (
        input  req_valid, req_char, tx_ready,
        output req_ack, tx_en, tx_char
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_transmit between
// NUM_REQUESTERS console sources, with optional whole-line locking.
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   bus          uart_tx_arbiter_if.slave (requesters + transmitter)
//   owner_valid  a requester currently holds the grant
//   owner_id     index of current or last owner
module uart_tx_arbiter #(
    parameter int         NUM_REQUESTERS = 4,
    parameter bit         LINE_LOCK      = 1'b1,
    parameter logic [7:0] EOL_CHAR       = 8'h0A,
    parameter int         LOCK_TIMEOUT   = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    uart_tx_arbiter_if.slave                  bus,
    output logic                              owner_valid,
    output logic [$clog2(NUM_REQUESTERS)-1:0] owner_id
);
    localparam int OW = $clog2(NUM_REQUESTERS);
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [OW-1:0] pick;
    logic          pick_found;
    logic          ov_q, ov_d;
    logic          eol_q, eol_d;
    logic          rel;
    logic [CW-1:0] idle_q, idle_d;

    // First valid requester after the last owner, wrapping around.
    always_comb begin : rr_pick
        int            idx;
        logic [OW-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            idx  = (int'(last_q) + k) % NUM_REQUESTERS;
            cand = OW'(idx);
            if (!pick_found && bus.req_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        ov_d        = ov_q;
        eol_d       = eol_q;
        idle_d      = idle_q;
        rel         = 1'b0;
        bus.tx_en   = 1'b0;
        bus.tx_char = '0;
        bus.req_ack = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick;
                    ov_d    = 1'b1;
                    idle_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.req_valid[owner_q]) begin
                    // A waiting owner is not idle, even if tx_ready is low.
                    idle_d = '0;
                    if (bus.tx_ready) begin
                        bus.tx_en            = 1'b1;
                        bus.tx_char          = bus.req_char[owner_q];
                        bus.req_ack[owner_q] = 1'b1;
                        eol_d   = (bus.req_char[owner_q] == EOL_CHAR);
                        state_d = DRAIN;
                    end
                end else if (!LINE_LOCK) begin
                    rel = 1'b1;
                end else if (int'(idle_q) + 1 >= LOCK_TIMEOUT) begin
                    idle_d = CW'(LOCK_TIMEOUT);
                    rel    = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            DRAIN: begin
                // Guard cycle: tx_ready only falls the cycle after tx_en.
                if (LINE_LOCK && !eol_q) begin
                    state_d = ISSUE;
                end else begin
                    rel = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rel) begin
            state_d = IDLE;
            last_d  = owner_q;
            ov_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQUESTERS - 1);
            ov_q    <= 1'b0;
            eol_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ov_q    <= ov_d;
            eol_q   <= eol_d;
            idle_q  <= idle_d;
        end
    end

    assign owner_valid = ov_q;
    assign owner_id    = owner_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and
// randomized lines checked against a transaction-level model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int         N   = 4;
    localparam logic [7:0] EOL = 8'h0A;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]      drv_valid [3];
    logic [N-1:0][7:0] drv_char  [3];
    logic              drv_ready [3];
    logic [N-1:0]      mon_ack   [3];
    logic              mon_en    [3];
    logic [7:0]        mon_char  [3];
    logic              mon_ov    [3];
    logic [1:0]        mon_id    [3];

    // 0: line lock, timeout 1024; 1: timeout 16; 2: no line lock
    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_arbiter_if #(.N(N)) bus ();
        assign bus.req_valid = drv_valid[g];
        assign bus.req_char  = drv_char[g];
        assign bus.tx_ready  = drv_ready[g];
        assign mon_ack[g]    = bus.req_ack;
        assign mon_en[g]     = bus.tx_en;
        assign mon_char[g]   = bus.tx_char;
        uart_tx_arbiter #(
            .NUM_REQUESTERS(N),
            .LINE_LOCK(g != 2),
            .EOL_CHAR(EOL),
            .LOCK_TIMEOUT(g == 1 ? 16 : 1024)
        ) dut (
            .clk(clk),
            .reset(reset_n),
            .bus(bus),
            .owner_valid(mon_ov[g]),
            .owner_id(mon_id[g])
        );
    end

    int tests_run = 0;
    int tests_failed = 0;
    int cur = 0;
    int rdy_pct = 100;
    logic prev_en = 1'b0;

    logic [7:0] q     [N][$];
    logic [7:0] mq    [N][$];
    logic [9:0] log_q [$];
    logic [9:0] exp_q [$];

    typedef struct {
        logic [3:0] valid;
        logic [7:0] c1;
        logic       rdy;
        logic       en;
        logic [7:0] ch;
        logic [3:0] ack;
        logic       ov;
        logic [1:0] id;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive queue heads, sample just after, pop acked chars.
    task automatic step();
        int   hit;
        logic ok;
        logic en;
        logic [N-1:0] ack;
        logic [7:0] ch;
        @(negedge clk);
        drv_ready[cur] = ($urandom_range(99, 0) < rdy_pct);
        for (int i = 0; i < N; i++) begin
            drv_valid[cur][i] = (q[i].size() != 0);
            drv_char[cur][i]  = (q[i].size() != 0) ? q[i][0] : 8'h00;
        end
        #1;
        en  = mon_en[cur];
        ack = mon_ack[cur];
        ch  = mon_char[cur];
        hit = -1;
        for (int i = 0; i < N; i++) if (ack[i]) hit = i;
        ok = $onehot0(ack) && (en == (ack != '0)) &&
             (!en || drv_ready[cur]) && (en || ch == 8'h00) &&
             !(en && prev_en);
        if (en && hit >= 0) begin
            ok = ok && drv_valid[cur][hit] && ch == drv_char[cur][hit] &&
                 mon_ov[cur] && int'(mon_id[cur]) == hit;
        end
        check($sformatf("proto dut%0d t=%0t", cur, $time), ok, 1);
        if (en && hit >= 0) begin
            log_q.push_back({2'(hit), ch});
            void'(q[hit].pop_front());
        end
        prev_en = en;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        for (int g = 0; g < 3; g++) begin
            drv_valid[g] = '0;
            drv_char[g]  = '0;
            drv_ready[g] = 1'b1;
        end
        log_q.delete();
        exp_q.delete();
        prev_en = 1'b0;
        rdy_pct = 100;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push_str(input int r, input string s, input bit eol);
        for (int i = 0; i < s.len(); i++) q[r].push_back(s[i]);
        if (eol) q[r].push_back(EOL);
    endtask

    task automatic push_exp(input int r, input string s, input bit eol);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({2'(r), s[i]});
        if (eol) exp_q.push_back({2'(r), EOL});
    endtask

    task automatic run_until(input int n, input int budget);
        int c;
        c = 0;
        while (log_q.size() < n && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic compare_log(input string name);
        int n;
        check({name, " count"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", name, i), log_q[i], exp_q[i]);
    endtask

    // Transaction-level model: round-robin over requesters with data,
    // whole lines when locked, single characters otherwise.
    task automatic build_expected(input bit lock);
        int   last;
        int   r;
        logic [7:0] c;
        bit   more;
        for (int i = 0; i < N; i++) mq[i] = q[i];
        exp_q.delete();
        last = N - 1;
        forever begin
            r = -1;
            for (int k = 1; k <= N; k++)
                if (r < 0 && mq[(last + k) % N].size() != 0)
                    r = (last + k) % N;
            if (r < 0) break;
            more = 1'b1;
            while (more && mq[r].size() != 0) begin
                c = mq[r].pop_front();
                exp_q.push_back({2'(r), c});
                more = lock && (c != EOL);
            end
            last = r;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0010, 8'h41, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{4'b0010, 8'h41, 1'b1, 1'b1, 8'h41, 4'b0010, 1'b1, 2'd1};
        tbl[2] = '{4'b0010, 8'h0A, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd1};
        tbl[3] = '{4'b0010, 8'h0A, 1'b1, 1'b1, 8'h0A, 4'b0010, 1'b1, 2'd1};
        tbl[4] = '{4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd1};
        tbl[5] = '{4'b0000, 8'h00, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
        tbl[6] = '{4'b0010, 8'h42, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1};
        tbl[7] = '{4'b0010, 8'h42, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd1};
        tbl[8] = '{4'b0010, 8'h42, 1'b1, 1'b1, 8'h42, 4'b0010, 1'b1, 2'd1};

        for (int g = 0; g < 3; g++) begin
            drv_valid[g] = '0;
            drv_char[g]  = '0;
            drv_ready[g] = 1'b1;
        end
        #1 reset_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++)
            check($sformatf("reset outputs dut%0d", g),
                  {mon_en[g], mon_char[g], mon_ack[g], mon_ov[g], mon_id[g]},
                  0);
        do_reset();

        // Line from requester 1, then a grant waiting on tx_ready.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drv_valid[0] = tbl[i].valid;
            drv_char[0]  = '0;
            drv_char[0][1] = tbl[i].c1;
            drv_ready[0] = tbl[i].rdy;
            #1;
            check($sformatf("t1 row%0d", i),
                  {mon_en[0], mon_char[0], mon_ack[0], mon_ov[0], mon_id[0]},
                  {tbl[i].en, tbl[i].ch, tbl[i].ack, tbl[i].ov, tbl[i].id});
        end

        // Two lines contending from reset, then fresh round.
        do_reset();
        cur = 0;
        push_str(0, "ab", 1);
        push_str(2, "cd", 1);
        push_exp(0, "ab", 1);
        push_exp(2, "cd", 1);
        run_until(6, 100);
        push_str(0, "e", 1);
        push_str(2, "f", 1);
        push_exp(0, "e", 1);
        push_exp(2, "f", 1);
        run_until(10, 100);
        compare_log("t2");

        // Lock timeout of 16 after an unterminated line.
        do_reset();
        cur = 1;
        push_str(0, "x", 0);
        push_str(3, "z", 1);
        run_until(1, 20);
        check("t3 first char", log_q.size() == 1 ? log_q[0] : 10'h3FF,
              {2'd0, 8'h78});
        for (int j = 1; j <= 19; j++) begin
            step();
            check($sformatf("t3 ov c+%0d", j), mon_ov[1], (j != 18));
            if (j == 18) check("t3 id kept", mon_id[1], 0);
            if (j == 19)
                check("t3 regrant", {mon_en[1], mon_id[1], mon_char[1]},
                      {1'b1, 2'd3, 8'h7A});
        end

        // No line lock: streams alternate per character.
        do_reset();
        cur = 2;
        push_str(0, "pqrs", 0);
        push_str(1, "PQRS", 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'd0, 8'h70 + 8'(i)});
            exp_q.push_back({2'd1, 8'h50 + 8'(i)});
        end
        run_until(8, 100);
        compare_log("t4");

        // Stalled transmitter must not look like an idle owner.
        do_reset();
        cur = 1;
        rdy_pct = 0;
        push_str(1, "k", 1);
        repeat (100) step();
        check("t5 no tx", log_q.size(), 0);
        check("t5 owner held", {mon_ov[1], mon_id[1]}, {1'b1, 2'd1});
        rdy_pct = 100;
        step();
        check("t5 tx on ready", log_q.size() == 1 ? log_q[0] : 10'h3FF,
              {2'd1, 8'h6B});

        // Asynchronous reset during DRAIN.
        do_reset();
        cur = 0;
        push_str(2, "m", 1);
        run_until(1, 20);
        @(posedge clk);
        #2;
        check("t6 drain owner", mon_ov[0], 1);
        reset_n = 1'b0;
        #1;
        check("t6 reset drop", {mon_en[0], mon_ack[0], mon_ov[0]}, 0);
        push_str(0, "u", 1);
        repeat (2) step();
        reset_n = 1'b1;
        prev_en = 1'b0;
        run_until(2, 20);
        check("t6 req0 first", log_q.size() >= 2 ? log_q[1] : 10'h3FF,
              {2'd0, 8'h75});

        // Random lines, random tx_ready, locked and unlocked.
        for (int rnd = 0; rnd < 10; rnd++) begin
            do_reset();
            cur = (rnd % 2 == 0) ? 0 : 2;
            rdy_pct = 70;
            for (int r = 0; r < N; r++) begin
                int lines;
                lines = $urandom_range(3, 0);
                for (int l = 0; l < lines; l++) begin
                    int len;
                    len = $urandom_range(4, 1);
                    for (int c = 0; c < len; c++)
                        q[r].push_back(8'($urandom_range(126, 32)));
                    q[r].push_back(EOL);
                end
            end
            build_expected(cur == 0);
            run_until(exp_q.size(), 2000);
            compare_log($sformatf("rand%0d", rnd));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
